// File: rtl/floo_rob_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// floo_rob_alloc_ctrl -- contiguous ROB slot allocator with drain control
// Revision: 1.0
// ============================================================================
module floo_rob_alloc_ctrl #(
    parameter int unsigned RobSize  = 64,
    parameter int unsigned MaxTxns  = 32,
    parameter int unsigned LenWidth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           alloc_valid_i,
    input  logic [LenWidth-1:0]            alloc_len_i,
    output logic                           alloc_ready_o,
    output logic [$clog2(RobSize)-1:0]     alloc_idx_o,
    output logic                           alloc_err_o,
    input  logic                           rel_valid_i,
    input  logic                           rel_last_i,
    output logic                           rel_err_o,
    input  logic                           drain_req_i,
    output logic                           drain_done_o,
    output logic [$clog2(RobSize+1)-1:0]   used_o,
    output logic [$clog2(MaxTxns+1)-1:0]   txn_cnt_o,
    output logic                           empty_o,
    output logic                           full_o
);

    localparam int unsigned IdxW  = $clog2(RobSize);
    localparam int unsigned UsedW = $clog2(RobSize + 1);
    localparam int unsigned TxnW  = $clog2(MaxTxns + 1);
    localparam int unsigned CmpW  = ((LenWidth + 1 > UsedW) ? LenWidth + 1 : UsedW) + 1;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   head_q, head_d;
    logic [IdxW-1:0]   tail_q, tail_d;
    logic [UsedW-1:0]  used_q, used_d;
    logic [TxnW-1:0]   txn_q, txn_d;
    logic              rel_err_q;

    logic [LenWidth:0] need;
    logic [CmpW-1:0]   need_w;
    logic [CmpW-1:0]   free_w;
    logic              oversize;
    logic              fits;
    logic              grant;
    logic              rel_ok;
    logic              rel_txn;

    // Ready looks only at registered occupancy; same-cycle releases are not bypassed.
    assign need     = {1'b0, alloc_len_i} + {{LenWidth{1'b0}}, 1'b1};
    assign need_w   = {{(CmpW - LenWidth - 1){1'b0}}, need};
    assign free_w   = CmpW'(RobSize) - {{(CmpW - UsedW){1'b0}}, used_q};
    assign oversize = need_w > CmpW'(RobSize);
    assign fits     = (txn_q < TxnW'(MaxTxns)) && (need_w <= free_w);

    assign alloc_ready_o = (state_q == ST_ACTIVE) && (fits || oversize);
    assign alloc_err_o   = alloc_valid_i && alloc_ready_o && oversize;
    assign grant         = alloc_valid_i && alloc_ready_o && !oversize;
    assign rel_ok        = rel_valid_i && (used_q != '0);
    assign rel_txn       = rel_ok && rel_last_i && (txn_q != '0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        used_d = used_q;
        txn_d  = txn_q;
        if (rel_ok) begin
            head_d = head_q + IdxW'(1);
        end
        if (grant) begin
            tail_d = tail_q + need_w[IdxW-1:0];
        end
        // A granted need never exceeds RobSize, so it fits in the used counter width.
        used_d = used_q + (grant ? need_w[UsedW-1:0] : '0) - (rel_ok ? UsedW'(1) : '0);
        txn_d  = txn_q + (grant ? TxnW'(1) : '0) - (rel_txn ? TxnW'(1) : '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_ACTIVE;
            head_q    <= '0;
            tail_q    <= '0;
            used_q    <= '0;
            txn_q     <= '0;
            rel_err_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            used_q    <= used_d;
            txn_q     <= txn_d;
            rel_err_q <= rel_valid_i && (used_q == '0);
            // Drain completion uses registered counts, so DRAIN lasts at least one cycle.
            case (state_q)
                ST_ACTIVE: begin
                    if (drain_req_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!drain_req_i) begin
                        state_q <= ST_ACTIVE;
                    end else if ((used_q == '0) && (txn_q == '0)) begin
                        state_q <= ST_DRAINED;
                    end
                end
                ST_DRAINED: begin
                    if (!drain_req_i) begin
                        state_q <= ST_ACTIVE;
                    end
                end
                default: begin
                    state_q <= ST_ACTIVE;
                end
            endcase
        end
    end

    assign alloc_idx_o  = tail_q;
    assign rel_err_o    = rel_err_q;
    assign drain_done_o = (state_q == ST_DRAINED);
    assign used_o       = used_q;
    assign txn_cnt_o    = txn_q;
    assign empty_o      = (used_q == '0);
    assign full_o       = (used_q == UsedW'(RobSize));

endmodule
`default_nettype wire
